// File: rtl/gnr_node_multi.sv
// Multi-channel GNR boolean-network node: per-channel activator/inhibitor update with a programmable step divider.
// Optional network-quiet detection is compiled in with `define GNR_STEADY_DET_EN.
module gnr_node_multi #(
    parameter int NUM_CH   = 2,
    parameter int NUM_IN   = 3,
    parameter int DIV_W    = 4,
    parameter int STEADY_N = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reset_nos,
    input  logic                       init_state,
    input  logic [NUM_CH-1:0]          start,
    input  logic [NUM_CH*DIV_W-1:0]    div,
    input  logic                       mode_or,
    input  logic [NUM_IN-1:0]          act_mask,
    input  logic [NUM_IN-1:0]          inh_mask,
    input  logic [NUM_CH*NUM_IN-1:0]   in_reg,
    output logic [NUM_CH-1:0]          s,
    output logic [NUM_CH-1:0]          changed,
    output logic                       steady
);

    logic [NUM_CH-1:0] nxt;
    logic [NUM_CH-1:0] eval_now;
    logic [NUM_CH-1:0] flip_now;
    logic [DIV_W-1:0]  cnt [NUM_CH];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt      = '0;
        eval_now = '0;
        flip_now = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nxt[c] = (mode_or ? |(in_reg[c*NUM_IN +: NUM_IN] & act_mask)
                              : &(in_reg[c*NUM_IN +: NUM_IN] | ~act_mask))
                     & ~|(in_reg[c*NUM_IN +: NUM_IN] & inh_mask);
            eval_now[c] = start[c] & ~reset_nos & (cnt[c] == '0);
            flip_now[c] = eval_now[c] & (nxt[c] != s[c]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s       <= '0;
            changed <= '0;
            // NOTE: cnt is a small flop array, not RAM, so it is deliberately cleared by reset.
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
        end else if (reset_nos) begin
            s       <= {NUM_CH{init_state}};
            changed <= '0;
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
        end else begin
            changed <= flip_now;
            for (int c = 0; c < NUM_CH; c++) begin
                if (start[c]) begin
                    if (cnt[c] == '0) begin
                        s[c]   <= nxt[c];
                        cnt[c] <= div[c*DIV_W +: DIV_W];
                    end else begin
                        cnt[c] <= cnt[c] - DIV_W'(1);
                    end
                end
            end
        end
    end

`ifdef GNR_STEADY_DET_EN
    localparam int QW = $clog2(STEADY_N + 1);

    logic [QW-1:0] quiet_cnt;

    // Cleared on the same edge that raises a changed pulse, so steady drops together with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quiet_cnt <= '0;
        end else if (reset_nos || (|flip_now)) begin
            quiet_cnt <= '0;
        end else if ((|eval_now) && (quiet_cnt != QW'(STEADY_N))) begin
            quiet_cnt <= quiet_cnt + QW'(1);
        end
    end

    assign steady = (quiet_cnt == QW'(STEADY_N));
`else
    // STEADY_N only sizes the quiet counter; referenced here so the parameter stays bound.
    assign steady = 1'b0 & (STEADY_N > 0);
`endif

endmodule
